// File: rtl/synthesijer_fcomp64_arbiter.sv
// synthesijer_fcomp64_arbiter
// Shares one 64-bit floating-point comparator between four requesters.
// A round-robin grant picks at most one lane per cycle, the lane's operands
// are registered onto the comparator port, and the lane index is queued in
// an in-order tag FIFO so each returning result is steered back to its owner.
//
// Optional build macro: SYNTHESIJER_FCOMP_ARB_CHECK_EN
//   defined   -> err is a sticky flag raised by a comparator result arriving
//                with nothing outstanding, or by a handshake into a full FIFO.
//   undefined -> err is tied to 0 and no checking logic is built.
//
// Handshake: requester lane i transfers a request on a rising clock edge when
// req_nd[i] & req_ready[i] is 1. req_ready is one-hot or zero, depends
// combinationally on req_nd, and never depends on cmp_valid, so a requester
// may hold req_nd high with stable operands until it sees req_ready.
module synthesijer_fcomp64_arbiter #(
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [255:0] req_a,
   input  logic [255:0] req_b,
   input  logic [31:0]  req_opcode,
   input  logic [3:0]   req_nd,
   output logic [3:0]   req_ready,
   output logic         rsp_result,
   output logic [3:0]   rsp_valid,
   output logic [63:0]  cmp_a,
   output logic [63:0]  cmp_b,
   output logic [7:0]   cmp_opcode,
   output logic         cmp_nd,
   input  logic         cmp_result,
   input  logic         cmp_valid,
   output logic [6:0]   outstanding,
   output logic         err
);

   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [6:0] DEPTH_CNT = 7'(DEPTH);

   // Round-robin search start pointer
   logic [1:0]    rr_ptr;

   // Grant selection
   logic [1:0]    cand;
   logic [1:0]    grant_idx;
   logic          grant_any;
   logic          handshake;

   // Selected lane operands
   logic [63:0]   sel_a;
   logic [63:0]   sel_b;
   logic [7:0]    sel_opcode;

   // Tag FIFO
   logic [1:0]    tag_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [6:0]    count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic [1:0]    head_tag;

   assign fifo_full   = (count == DEPTH_CNT);
   assign fifo_empty  = (count == 7'd0);
   assign pop         = cmp_valid & ~fifo_empty;
   assign head_tag    = tag_mem[rd_ptr];
   assign handshake   = |(req_nd & req_ready);
   assign outstanding = count;

   // Round-robin search from rr_ptr; readiness withheld when full or in reset
   always_comb begin
      cand      = rr_ptr;
      grant_idx = 2'd0;
      grant_any = 1'b0;
      req_ready = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         cand = rr_ptr + 2'(i);
         if (!grant_any && req_nd[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
      if (grant_any && !fifo_full && !reset) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Operand mux for the granted lane
   always_comb begin
      sel_a      = req_a[63:0];
      sel_b      = req_b[63:0];
      sel_opcode = req_opcode[7:0];
      case (grant_idx)
         2'd1: begin
            sel_a      = req_a[127:64];
            sel_b      = req_b[127:64];
            sel_opcode = req_opcode[15:8];
         end
         2'd2: begin
            sel_a      = req_a[191:128];
            sel_b      = req_b[191:128];
            sel_opcode = req_opcode[23:16];
         end
         2'd3: begin
            sel_a      = req_a[255:192];
            sel_b      = req_b[255:192];
            sel_opcode = req_opcode[31:24];
         end
         default: begin
            sel_a      = req_a[63:0];
            sel_b      = req_b[63:0];
            sel_opcode = req_opcode[7:0];
         end
      endcase
   end

   // Advance the round-robin pointer past each granted lane
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= 2'd0;
      end else if (handshake) begin
         rr_ptr <= grant_idx + 2'd1;
      end
   end

   // Issue register: operands held between issues, strobe lasts one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmp_a      <= 64'd0;
         cmp_b      <= 64'd0;
         cmp_opcode <= 8'd0;
         cmp_nd     <= 1'b0;
      end else begin
         cmp_nd <= handshake;
         if (handshake) begin
            cmp_a      <= sel_a;
            cmp_b      <= sel_b;
            cmp_opcode <= sel_opcode;
         end
      end
   end

   // Tag storage needs no reset: entries are only read behind the write pointer
   always_ff @(posedge clk) begin
      if (handshake) begin
         tag_mem[wr_ptr] <= grant_idx;
      end
   end

   // Tag FIFO pointers and occupancy; simultaneous push and pop cancel out
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 7'd0;
      end else begin
         if (handshake) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({handshake, pop})
            2'b10:   count <= count + 7'd1;
            2'b01:   count <= count - 7'd1;
            default: count <= count;
         endcase
      end
   end

   // Response steering: result held between responses, valid pulses one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_result <= 1'b0;
         rsp_valid  <= 4'b0000;
      end else begin
         if (pop) begin
            rsp_result <= cmp_result;
            rsp_valid  <= 4'b0001 << head_tag;
         end else begin
            rsp_valid  <= 4'b0000;
         end
      end
   end

`ifdef SYNTHESIJER_FCOMP_ARB_CHECK_EN
   logic err_q;

   // Sticky protocol error: orphan comparator result or overflowing push
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if ((cmp_valid && fifo_empty) || (handshake && fifo_full)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_synthesijer_fcomp64_arbiter.sv
// Testbench for synthesijer_fcomp64_arbiter.
// Inputs change 1 ns after a rising edge; outputs are checked on the falling
// edge. A reference model (round-robin pointer, occupancy, tag queue) predicts
// grants, and expected comparator issues and responses are queued for the
// following cycle.
module tb_synthesijer_fcomp64_arbiter;

   localparam int DEPTH = 16;

   logic         clk;
   logic         reset;
   logic [255:0] req_a;
   logic [255:0] req_b;
   logic [31:0]  req_opcode;
   logic [3:0]   req_nd;
   logic [3:0]   req_ready;
   logic         rsp_result;
   logic [3:0]   rsp_valid;
   logic [63:0]  cmp_a;
   logic [63:0]  cmp_b;
   logic [7:0]   cmp_opcode;
   logic         cmp_nd;
   logic         cmp_result;
   logic         cmp_valid;
   logic [6:0]   outstanding;
   logic         err;

   synthesijer_fcomp64_arbiter #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_opcode  (req_opcode),
      .req_nd      (req_nd),
      .req_ready   (req_ready),
      .rsp_result  (rsp_result),
      .rsp_valid   (rsp_valid),
      .cmp_a       (cmp_a),
      .cmp_b       (cmp_b),
      .cmp_opcode  (cmp_opcode),
      .cmp_nd      (cmp_nd),
      .cmp_result  (cmp_result),
      .cmp_valid   (cmp_valid),
      .outstanding (outstanding),
      .err         (err)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int           p_m;
   int           count_m;
   bit           err_m;
   logic [1:0]   tag_q[$];
   logic [135:0] exp_issue_q[$];
   logic [2:0]   exp_rsp_q[$];
   logic [63:0]  last_a;
   logic [63:0]  last_b;
   logic [7:0]   last_op;
   logic         last_res;
   int           grant_log[$];

   task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      p_m      = 0;
      count_m  = 0;
      err_m    = 1'b0;
      last_a   = 64'd0;
      last_b   = 64'd0;
      last_op  = 8'd0;
      last_res = 1'b0;
      tag_q.delete();
      exp_issue_q.delete();
      exp_rsp_q.delete();
   endtask

   task automatic rand_ops();
      for (int i = 0; i < 4; i++) begin
         req_a[i*64 +: 64]    = {$urandom, $urandom};
         req_b[i*64 +: 64]    = {$urandom, $urandom};
         req_opcode[i*8 +: 8] = 8'($urandom_range(0, 255));
      end
   endtask

   // One clock cycle: drive, then check last cycle's outputs and predict this one
   task automatic step(input logic [3:0] nd, input logic cv, input logic cr, input bit rnd);
      logic [135:0] ie;
      logic [2:0]   re;
      logic [3:0]   exp_ready;
      int           g;
      int           c;
      bit           found;
      @(posedge clk);
      #1;
      if (rnd) rand_ops();
      req_nd     = nd;
      cmp_valid  = cv;
      cmp_result = cr;
      @(negedge clk);
      // Issue from the previous cycle's handshake
      if (exp_issue_q.size() > 0) begin
         ie = exp_issue_q.pop_front();
         chk("cmp_nd", cmp_nd, 1'b1);
         last_a  = ie[135:72];
         last_b  = ie[71:8];
         last_op = ie[7:0];
      end else begin
         chk("cmp_nd", cmp_nd, 1'b0);
      end
      chk("cmp_a", cmp_a, last_a);
      chk("cmp_b", cmp_b, last_b);
      chk("cmp_opcode", cmp_opcode, last_op);
      // Response from the previous cycle's pop
      if (exp_rsp_q.size() > 0) begin
         re = exp_rsp_q.pop_front();
         chk("rsp_valid", rsp_valid, 4'b0001 << re[2:1]);
         last_res = re[0];
      end else begin
         chk("rsp_valid", rsp_valid, 4'b0000);
      end
      chk("rsp_result", rsp_result, last_res);
      chk("outstanding", outstanding, 7'(count_m));
      chk("err", err, err_m);
      // Predict this cycle's grant
      exp_ready = 4'b0000;
      found = 1'b0;
      g = 0;
      if (count_m < DEPTH) begin
         for (int i = 0; i < 4; i++) begin
            c = (p_m + i) % 4;
            if (!found && nd[c]) begin
               found = 1'b1;
               g = c;
            end
         end
      end
      if (found) exp_ready[g] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
`ifdef SYNTHESIJER_FCOMP_ARB_CHECK_EN
      if (cv && count_m == 0) err_m = 1'b1;
`endif
      if (cv && count_m > 0) begin
         exp_rsp_q.push_back({tag_q.pop_front(), cr});
         count_m--;
      end
      if (found) begin
         tag_q.push_back(2'(g));
         exp_issue_q.push_back({req_a[g*64 +: 64], req_b[g*64 +: 64], req_opcode[g*8 +: 8]});
         grant_log.push_back(g);
         p_m = (g + 1) % 4;
         count_m++;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset     = 1'b1;
      req_nd    = 4'hF;
      cmp_valid = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 4'b0000);
      chk("rst_outstanding", outstanding, 7'd0);
      chk("rst_cmp_nd", cmp_nd, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 4'b0000);
      chk("rst_rsp_result", rsp_result, 1'b0);
      chk("rst_cmp_a", cmp_a, 64'd0);
      chk("rst_cmp_b", cmp_b, 64'd0);
      chk("rst_cmp_opcode", cmp_opcode, 8'd0);
      chk("rst_err", err, 1'b0);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      req_nd    = 4'h0;
      cmp_valid = 1'b0;
      model_reset();
   endtask

   initial begin
      reset      = 1'b1;
      req_a      = '0;
      req_b      = '0;
      req_opcode = '0;
      req_nd     = 4'h0;
      cmp_result = 1'b0;
      cmp_valid  = 1'b0;
      model_reset();
      do_reset();

      // Single request on lane 2: 1.0 vs 2.0, opcode 0x0C, result after 3 cycles
      req_a[191:128]    = 64'h3FF0_0000_0000_0000;
      req_b[191:128]    = 64'h4000_0000_0000_0000;
      req_opcode[23:16] = 8'h0C;
      step(4'b0100, 1'b0, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      chk("single_outstanding_1", outstanding, 7'd1);
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      step(4'b0000, 1'b1, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      chk("single_rsp_lane2", rsp_valid, 4'b0100);
      chk("single_rsp_result", rsp_result, 1'b1);
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      chk("single_outstanding_0", outstanding, 7'd0);

      // All four lanes requesting for 8 cycles from reset
      do_reset();
      grant_log.delete();
      for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 1'b0, 1'b1);
      chk("rr_grants", {grant_log[0], grant_log[1], grant_log[2], grant_log[3],
                        grant_log[4], grant_log[5], grant_log[6], grant_log[7]},
          {32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3});
      for (int i = 0; i < 9; i++) step(4'b0000, (i < 8), 1'($urandom_range(0, 1)), 1'b0);

      // Stalled comparator: fill to DEPTH, one result frees exactly one slot
      do_reset();
      grant_log.delete();
      for (int i = 0; i < 20; i++) step(4'b1111, 1'b0, 1'b0, 1'b1);
      chk("stall_grants", grant_log.size(), DEPTH);
      chk("stall_full", outstanding, 7'(DEPTH));
      step(4'b1111, 1'b1, 1'b1, 1'b1);
      chk("stall_no_grant_on_pop", req_ready, 4'b0000);
      step(4'b1111, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0, 1'b1);
      chk("stall_grants_after", grant_log.size(), DEPTH + 1);
      chk("stall_outstanding", outstanding, 7'(DEPTH));
      for (int i = 0; i < DEPTH + 1; i++) step(4'b0000, (i < DEPTH), 1'($urandom_range(0, 1)), 1'b0);
      chk("stall_drained", outstanding, 7'd0);

      // Occupancy 5, then simultaneous push and pop across pointer wrap
      do_reset();
      for (int i = 0; i < 5; i++) step(4'($urandom_range(1, 15)), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) step(4'($urandom_range(1, 15)), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      chk("pushpop_outstanding", outstanding, 7'd5);
      for (int i = 0; i < 6; i++) step(4'b0000, (i < 5), 1'($urandom_range(0, 1)), 1'b0);

      // Reset with three operations in flight, then a late comparator result
      do_reset();
      for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      chk("pre_reset_outstanding", outstanding, 7'd3);
      do_reset();
      step(4'b0000, 1'b1, 1'b1, 1'b0);
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      chk("late_rsp_valid", rsp_valid, 4'b0000);
      chk("late_outstanding", outstanding, 7'd0);
`ifdef SYNTHESIJER_FCOMP_ARB_CHECK_EN
      chk("late_err", err, 1'b1);
`else
      chk("late_err", err, 1'b0);
`endif
      step(4'b0000, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
